axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Sits downstream of the Icache and Dcache refill engines. It is the single owner of the CPU's AXI3 read-address and read-data channels.
- Accepts burst read requests from both caches, grants one at a time with round-robin fairness, drives AR, and steers returning R beats to the granted cache.
- Checks beat count against arlen.
- Write channels are outside this block; it only receives a write-busy hint for ordering.

Parameters:
I_ARID, 4'd0, arid driven for Icache bursts
D_ARID, 4'd1, arid driven for Dcache bursts

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
i_araddr  in  32  Icache burst start address
i_arlen  in  4  Icache burst length minus 1
i_arvalid  in  1  Icache request; held until i_arready
i_arready  out  1  Icache request accepted (1-cycle pulse)
d_araddr  in  32  Dcache burst start address
d_arlen  in  4  Dcache burst length minus 1
d_arvalid  in  1  Dcache request; held until d_arready
d_arready  out  1  Dcache request accepted (1-cycle pulse)
d_wr_busy  in  1  Dcache write burst in flight; blocks Dcache read grant
cli_rdata  out  32  returned beat data, shared by both caches
cli_rlast  out  1  last beat of current burst
i_rvalid  out  1  beat valid for Icache
d_rvalid  out  1  beat valid for Dcache
arid  out  4  AXI read ID
araddr  out  32  AXI read address
arlen  out  4  AXI burst length
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rdata  in  32  AXI read data
rresp  in  2  AXI read response
rlast  in  1  AXI last beat
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rd_err  out  1  sticky protocol/response error

Behaviour:
- All outputs are 0 on reset: arvalid, arid, araddr, arlen, i_arready, d_arready, rd_err, rready, and the per-cache valids. The round-robin pointer resets to "Dcache preferred".
- AXI attribute fields (size=word, burst=INCR, lock, cache, prot) are tied off outside this block.
- FSM states are IDLE, ADDR and DATA.
- IDLE, arbitration:
  - Eligible requests are i_arvalid, and d_arvalid & !d_wr_busy.
  - One eligible request: grant it.
  - Both eligible: grant the side the pointer prefers, then flip the pointer to the other side.
  - On grant, in the same edge: latch addr/len/id into araddr/arlen/arid, assert arvalid, pulse the granted side's x_arready for exactly that cycle, and go to ADDR.
  - Grant latency: request visible at cycle N gives x_arready=1 at N and arvalid=1 at N+1.
- ADDR:
  - Hold arvalid and the latched fields stable until arvalid&arready.
  - On that edge: drop arvalid, clear the beat counter to 0, set rready=1, and go to DATA.
- DATA:
  - rready=1.
  - cli_rdata=rdata and cli_rlast=rlast, combinational.
  - The granted side's x_rvalid=rvalid; the other side's x_rvalid=0.
  - The beat counter (4 bits) increments on each rvalid.
  - On rvalid&rlast, go to IDLE and clear rready. A new grant may occur in the first IDLE cycle, giving 1 idle cycle between bursts.
- Error checks, all setting sticky rd_err (cleared only by reset):
  - rlast arriving with counter != arlen.
  - counter == arlen with rvalid but without rlast: beat is delivered, FSM stays in DATA until rlast.
  - rresp != 0 on any beat: data is still delivered.
- rvalid outside DATA: ignored. Neither x_rvalid is raised, and rd_err is set.
- Dcache ordering: while d_wr_busy=1, a Dcache request is never granted. An Icache request may still be granted. d_wr_busy rising during ADDR/DATA of a Dcache burst has no effect on that burst.
- A request dropped by a cache before its grant is not a legal use. The block does not protect against it.
- Reset asserted mid-burst: immediate return to IDLE with all outputs at their reset values. The AXI slave is reset by the same system reset.
- arlen=0 (single beat): DATA ends on the first beat, which must carry rlast.

Test Plan:
- Icache only: i_araddr=0xBFC00000, i_arlen=7; slave arready after 2 cycles, 8 beats 0x1..0x8 with rlast on beat 8 -> i_arready single pulse, arid=0, arlen=7, i_rvalid on 8 beats with cli_rdata 0x1..0x8, d_rvalid never 1, rd_err=0.
- Simultaneous requests from reset, I(0x1000,len 3) and D(0x2000,len 3), held -> D granted first (arid=1, araddr=0x2000), then I (araddr=0x1000). Repeat both again -> order I then D, i.e. alternation.
- d_wr_busy=1 with D and I both requesting -> I granted, D waits. Drop d_wr_busy -> D granted in the next IDLE cycle.
- Slave gives rlast on beat 3 of an arlen=7 burst -> burst ends, rd_err=1 and stays 1 across later clean bursts.
- rresp=2'b10 on beat 2 of 4 -> all 4 beats delivered, rd_err=1.
- Reset asserted during DATA beat 2 -> arvalid, rready, x_rvalid and rd_err all 0 immediately. After release, a new I request completes normally.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: cache refill requests/responses and the shared AXI3 read channels
interface axi_read_arbiter_if;
    logic [31:0] i_araddr;
    logic [3:0]  i_arlen;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] d_araddr;
    logic [3:0]  d_arlen;
    logic        d_arvalid;
    logic        d_arready;
    logic        d_wr_busy;
    logic [31:0] cli_rdata;
    logic        cli_rlast;
    logic        i_rvalid;
    logic        d_rvalid;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        rd_err;
    modport master (
        input  i_araddr, i_arlen, i_arvalid, d_araddr, d_arlen, d_arvalid, d_wr_busy,
        input  arready, rdata, rresp, rlast, rvalid,
        output i_arready, d_arready, cli_rdata, cli_rlast, i_rvalid, d_rvalid,
        output arid, araddr, arlen, arvalid, rready, rd_err
    );
    modport slave (
        output i_araddr, i_arlen, i_arvalid, d_araddr, d_arlen, d_arvalid, d_wr_busy,
        output arready, rdata, rresp, rlast, rvalid,
        input  i_arready, d_arready, cli_rdata, cli_rlast, i_rvalid, d_rvalid,
        input  arid, araddr, arlen, arvalid, rready, rd_err
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin Icache/Dcache burst read arbiter owning the AXI3 AR/R channels
module axi_read_arbiter #(
    parameter logic [3:0] I_ARID = 4'd0,
    parameter logic [3:0] D_ARID = 4'd1
) (
    input logic clk,
    input logic reset,
    axi_read_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nxt;
    logic ptr_d, gnt_d, i_el, d_el, pick_d, grant, beat, bad_beat;
    logic [3:0] cnt;
    assign i_el = bus.i_arvalid;
    assign d_el = bus.d_arvalid & ~bus.d_wr_busy;
    assign pick_d = d_el & (~i_el | ptr_d);
    assign grant = reset & (state == IDLE) & (i_el | d_el);
    assign bus.i_arready = grant & ~pick_d;
    assign bus.d_arready = grant & pick_d;
    assign bus.arvalid = state == ADDR;
    assign bus.rready = state == DATA;
    assign beat = (state == DATA) & bus.rvalid;
    assign bus.i_rvalid = beat & ~gnt_d;
    assign bus.d_rvalid = beat & gnt_d;
    assign bus.cli_rdata = bus.rdata;
    assign bus.cli_rlast = (state == DATA) & bus.rlast;
    // any rvalid outside DATA, a bad response, or rlast disagreeing with the beat count
    assign bad_beat = bus.rvalid & ((state != DATA) | (bus.rresp != 2'b00) | (bus.rlast != (cnt == bus.arlen)));
    always_comb begin
        state_nxt = state;
        if (grant) state_nxt = ADDR;
        if (state == ADDR && bus.arready) state_nxt = DATA;
        if (beat && bus.rlast) state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr_d      <= 1'b1;
            gnt_d      <= 1'b0;
            cnt        <= 4'd0;
            bus.rd_err <= 1'b0;
            bus.arid   <= 4'd0;
            bus.araddr <= 32'd0;
            bus.arlen  <= 4'd0;
        end else begin
            state <= state_nxt;
            if (bad_beat) bus.rd_err <= 1'b1;
            if (grant) begin
                gnt_d      <= pick_d;
                bus.arid   <= pick_d ? D_ARID : I_ARID;
                bus.araddr <= pick_d ? bus.d_araddr : bus.i_araddr;
                bus.arlen  <= pick_d ? bus.d_arlen : bus.i_arlen;
                if (i_el && d_el) ptr_d <= ~pick_d;
            end
            if (state == ADDR) cnt <= 4'd0;
            else if (beat) cnt <= cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed checks of arbitration, beat steering and error flagging
module tb_axi_read_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;
    axi_read_arbiter_if bus ();
    axi_read_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cyc();
    endtask
    // Expects the requesting side already driven; serves one full burst as the AXI slave.
    task automatic serve(input bit is_d, input logic [31:0] addr, input logic [3:0] len,
                         input int nbeats, input int bad, input int ar_delay, input logic [31:0] base);
        int k = 0;
        #1;
        while (!(is_d ? bus.d_arready : bus.i_arready) && k < 20) begin
            cyc();
            k++;
        end
        chk("grant_wait", 32'(k < 20), 1);
        chk("other_arready", is_d ? bus.i_arready : bus.d_arready, 0);
        cyc();
        chk("arready_pulse", is_d ? bus.d_arready : bus.i_arready, 0);
        if (is_d) bus.d_arvalid = 1'b0;
        else bus.i_arvalid = 1'b0;
        chk("arvalid", bus.arvalid, 1);
        chk("arid", bus.arid, is_d ? 1 : 0);
        chk("araddr", bus.araddr, addr);
        chk("arlen", bus.arlen, len);
        for (int i = 0; i < ar_delay; i++) begin
            cyc();
            chk("ar_hold", {bus.arvalid, bus.araddr[3:0]}, {1'b1, addr[3:0]});
        end
        bus.arready = 1'b1;
        cyc();
        bus.arready = 1'b0;
        chk("arvalid_drop", bus.arvalid, 0);
        chk("rready", bus.rready, 1);
        for (int b = 0; b < nbeats; b++) begin
            bus.rvalid = 1'b1;
            bus.rdata = base + 32'(b);
            bus.rlast = (b == nbeats - 1);
            bus.rresp = (b == bad) ? 2'b10 : 2'b00;
            #1;
            chk("x_rvalid", {bus.i_rvalid, bus.d_rvalid}, is_d ? 2'b01 : 2'b10);
            chk("cli_rdata", bus.cli_rdata, base + 32'(b));
            cyc();
            bus.rvalid = 1'b0;
            bus.rlast = 1'b0;
            bus.rresp = 2'b00;
        end
        chk("rready_end", bus.rready, 0);
    endtask
    initial begin
        bus.i_araddr = 0; bus.i_arlen = 0; bus.i_arvalid = 1'b1;
        bus.d_araddr = 0; bus.d_arlen = 0; bus.d_arvalid = 1'b0; bus.d_wr_busy = 1'b0;
        bus.arready = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
        #12;
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_i_arready", bus.i_arready, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_rd_err", bus.rd_err, 0);
        chk("rst_fields", {bus.arid, bus.araddr, bus.arlen}, 0);
        bus.i_arvalid = 1'b0;
        do_reset();
        // Icache only, 8 beats, slave waits 2 cycles on AR
        bus.i_araddr = 32'hBFC0_0000; bus.i_arlen = 4'd7; bus.i_arvalid = 1'b1;
        serve(0, 32'hBFC0_0000, 4'd7, 8, -1, 2, 32'h1);
        chk("rd_err_clean", bus.rd_err, 0);
        // single beat burst
        bus.i_araddr = 32'h40; bus.i_arlen = 4'd0; bus.i_arvalid = 1'b1;
        serve(0, 32'h40, 4'd0, 1, -1, 0, 32'hAA);
        chk("rd_err_single", bus.rd_err, 0);
        // simultaneous: D preferred first, then alternation
        bus.i_araddr = 32'h1000; bus.i_arlen = 4'd3; bus.i_arvalid = 1'b1;
        bus.d_araddr = 32'h2000; bus.d_arlen = 4'd3; bus.d_arvalid = 1'b1;
        serve(1, 32'h2000, 4'd3, 4, -1, 0, 32'h100);
        serve(0, 32'h1000, 4'd3, 4, -1, 0, 32'h200);
        bus.i_arvalid = 1'b1; bus.d_arvalid = 1'b1;
        serve(0, 32'h1000, 4'd3, 4, -1, 0, 32'h300);
        serve(1, 32'h2000, 4'd3, 4, -1, 0, 32'h400);
        // write-busy blocks Dcache
        bus.d_wr_busy = 1'b1;
        bus.i_arvalid = 1'b1; bus.d_arvalid = 1'b1;
        serve(0, 32'h1000, 4'd3, 4, -1, 0, 32'h500);
        cyc();
        chk("busy_block", bus.d_arready, 0);
        bus.d_wr_busy = 1'b0;
        #1;
        chk("busy_release", bus.d_arready, 1);
        serve(1, 32'h2000, 4'd3, 4, -1, 0, 32'h600);
        chk("rd_err_pre", bus.rd_err, 0);
        // early rlast on beat 3 of an 8-beat burst
        bus.i_araddr = 32'h5000; bus.i_arlen = 4'd7; bus.i_arvalid = 1'b1;
        serve(0, 32'h5000, 4'd7, 3, -1, 0, 32'h700);
        chk("early_rlast_err", bus.rd_err, 1);
        bus.i_araddr = 32'h6000; bus.i_arlen = 4'd1; bus.i_arvalid = 1'b1;
        serve(0, 32'h6000, 4'd1, 2, -1, 0, 32'h800);
        chk("rd_err_sticky", bus.rd_err, 1);
        // bad rresp on beat 2 of 4
        do_reset();
        chk("rd_err_cleared", bus.rd_err, 0);
        bus.d_araddr = 32'h7000; bus.d_arlen = 4'd3; bus.d_arvalid = 1'b1;
        serve(1, 32'h7000, 4'd3, 4, 1, 0, 32'h900);
        chk("rresp_err", bus.rd_err, 1);
        // reset during beat 2
        bus.i_araddr = 32'h8000; bus.i_arlen = 4'd3; bus.i_arvalid = 1'b1;
        cyc();
        bus.i_arvalid = 1'b0; bus.arready = 1'b1;
        cyc();
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hA1;
        cyc();
        bus.rdata = 32'hA2;
        #1;
        chk("beat2_live", bus.i_rvalid, 1);
        reset = 1'b0;
        #1;
        chk("midrst_outs", {bus.arvalid, bus.rready, bus.i_rvalid, bus.d_rvalid, bus.rd_err}, 0);
        bus.rvalid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        bus.i_araddr = 32'h9000; bus.i_arlen = 4'd3; bus.i_arvalid = 1'b1;
        serve(0, 32'h9000, 4'd3, 4, -1, 1, 32'hB00);
        chk("post_rst_err", bus.rd_err, 0);
        // stray rvalid while idle
        bus.rvalid = 1'b1;
        #1;
        chk("stray_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
        cyc();
        bus.rvalid = 1'b0;
        chk("stray_err", bus.rd_err, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
